// File: rtl/mfp_param_digit_display.sv
// Time-multiplexed N-digit hex seven-segment driver with frame-synchronous input capture,
// PWM brightness and anti-ghost blanking. Optional macro: MFP_DISPLAY_LEADING_ZERO_BLANK_EN.
module mfp_param_digit_display #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_LOG2 = 14,
  parameter int BRIGHT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] number,
  input  logic [N_DIGITS-1:0]   dots,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [6:0]            seven_segments,
  output logic                  dot,
  output logic [N_DIGITS-1:0]   anodes,
  output logic                  frame_tick
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [REFRESH_LOG2-1:0] r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*N_DIGITS-1:0]   r_number;
  logic [N_DIGITS-1:0]     r_dots;
  logic [N_DIGITS-1:0]     r_digit_en;
  logic [BRIGHT_W-1:0]     r_brightness;
  logic [6:0]              r_segments;
  logic                    r_dot;
  logic [N_DIGITS-1:0]     r_anodes;

  logic                    w_cnt_wrap;
  logic                    w_idx_last;
  logic                    w_frame_start;
  logic [BRIGHT_W-1:0]     w_pwm_phase;
  logic                    w_lit;
  logic                    w_blank;
  logic [3:0]              w_nibbles [N_DIGITS];
  logic [N_DIGITS-1:0]     w_lz_dark;
  logic                    w_digit_on;
  logic [N_DIGITS-1:0]     w_anodes_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'b1000000;
      4'h1: hex_to_seg = 7'b1111001;
      4'h2: hex_to_seg = 7'b0100100;
      4'h3: hex_to_seg = 7'b0110000;
      4'h4: hex_to_seg = 7'b0011001;
      4'h5: hex_to_seg = 7'b0010010;
      4'h6: hex_to_seg = 7'b0000010;
      4'h7: hex_to_seg = 7'b1111000;
      4'h8: hex_to_seg = 7'b0000000;
      4'h9: hex_to_seg = 7'b0010000;
      4'hA: hex_to_seg = 7'b0001000;
      4'hB: hex_to_seg = 7'b0000011;
      4'hC: hex_to_seg = 7'b1000110;
      4'hD: hex_to_seg = 7'b0100001;
      4'hE: hex_to_seg = 7'b0000110;
      4'hF: hex_to_seg = 7'b0001110;
      default: hex_to_seg = 7'b1111111;
    endcase
  endfunction

  assign w_cnt_wrap    = &r_cnt;
  assign w_idx_last    = (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_frame_start = (r_cnt == '0) && (r_idx == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= r_cnt + REFRESH_LOG2'(1);
      if (w_cnt_wrap) begin
        r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // Shadows load at the end of the frame's first cycle; that cycle is blanked, so no torn digit shows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_number     <= '0;
      r_dots       <= '0;
      r_digit_en   <= '0;
      r_brightness <= '0;
    end else if (w_frame_start) begin
      r_number     <= number;
      r_dots       <= dots;
      r_digit_en   <= digit_en;
      r_brightness <= brightness;
    end
  end

  always_comb begin
    for (int i = 0; i < N_DIGITS; i++) begin
      w_nibbles[i] = r_number[4*i +: 4];
    end
  end

`ifdef MFP_DISPLAY_LEADING_ZERO_BLANK_EN
  always_comb begin : lz_blank
    logic upper_zero;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    w_lz_dark  = '0;
    upper_zero = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      upper_zero   = upper_zero & (w_nibbles[i] == 4'h0);
      w_lz_dark[i] = upper_zero;
    end
  end
`else
  assign w_lz_dark = '0;
`endif

  assign w_pwm_phase = r_cnt[REFRESH_LOG2-1 -: BRIGHT_W];
  assign w_lit       = (&r_brightness) || (w_pwm_phase < r_brightness);
  assign w_blank     = (r_cnt < REFRESH_LOG2'(2));
  assign w_digit_on  = r_digit_en[r_idx] & ~w_lz_dark[r_idx];

  always_comb begin
    w_anodes_nxt = '1;
    if (w_lit && !w_blank && w_digit_on) begin
      w_anodes_nxt[r_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_segments <= 7'b1111111;
      r_dot      <= 1'b1;
      r_anodes   <= '1;
    end else begin
      r_segments <= hex_to_seg(w_nibbles[r_idx]);
      r_dot      <= ~r_dots[r_idx];
      r_anodes   <= w_anodes_nxt;
    end
  end

  assign seven_segments = r_segments;
  assign dot            = r_dot;
  assign anodes         = r_anodes;
  // Gated by rst so the pulse is low while reset holds cnt/idx at the frame-start state.
  assign frame_tick     = w_frame_start & ~rst;

endmodule

// File: tb/tb_mfp_param_digit_display.sv
// Randomized self-checking bench for mfp_param_digit_display against a time-indexed reference model.
// Honors MFP_DISPLAY_LEADING_ZERO_BLANK_EN the same way as the design.
module tb_mfp_param_digit_display;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int BW = 4;
  localparam int S  = 1 << R;
  localparam int F  = N * S;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic          clk = 1'b0;
  logic          rst;
  logic [4*N-1:0] number;
  logic [N-1:0]   dots;
  logic [N-1:0]   digit_en;
  logic [BW-1:0]  brightness;
  logic [6:0]     seven_segments;
  logic           dot;
  logic [N-1:0]   anodes;
  logic           frame_tick;

  mfp_param_digit_display #(
    .N_DIGITS    (N),
    .REFRESH_LOG2(R),
    .BRIGHT_W    (BW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .number        (number),
    .dots          (dots),
    .digit_en      (digit_en),
    .brightness    (brightness),
    .seven_segments(seven_segments),
    .dot           (dot),
    .anodes        (anodes),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_t counts cycles since reset release; frame-start inputs are latched at multiples of F.
  int             m_t;
  logic [4*N-1:0] m_num;
  logic [N-1:0]   m_dots;
  logic [N-1:0]   m_en;
  logic [BW-1:0]  m_bright;
  logic [N-1:0]   exp_an;
  logic [6:0]     exp_seg;
  logic           exp_dot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0d: got %h, expected %h", tag, m_t, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_anodes"}, 32'(anodes), 32'hF);
    check({tag, "_seg"}, 32'(seven_segments), 32'h7F);
    check({tag, "_dot"}, 32'(dot), 32'h1);
    check({tag, "_tick"}, 32'(frame_tick), 32'h0);
  endtask

  task automatic release_rst();
    rst = 1'b0;
    #1;
    m_t      = 0;
    m_num    = '0;
    m_dots   = '0;
    m_en     = '0;
    m_bright = '0;
    exp_an   = '1;
    exp_seg  = 7'h7F;
    exp_dot  = 1'b1;
  endtask

  // Called mid-cycle m_t with this cycle's inputs already applied.
  task automatic step();
    int  c, i, nib, num, pwm;
    bit  lit, on;
    check("frame_tick", 32'(frame_tick), 32'((m_t % F) == 0));
    check("anodes", 32'(anodes), 32'(exp_an));
    check("segments", 32'(seven_segments), 32'(exp_seg));
    check("dot", 32'(dot), 32'(exp_dot));

    c   = m_t % S;
    i   = (m_t / S) % N;
    num = int'(m_num);
    nib = (num >> (4 * i)) & 15;
    pwm = c >> (R - BW);
    lit = (int'(m_bright) == (1 << BW) - 1) || (pwm < int'(m_bright));
    on  = m_en[i];
`ifdef MFP_DISPLAY_LEADING_ZERO_BLANK_EN
    if (i > 0 && (num >> (4 * i)) == 0) on = 1'b0;
`endif
    exp_an = '1;
    if (lit && c >= 2 && on) exp_an = N'(~(1 << i));
    exp_seg = SEG_TAB[nib];
    exp_dot = ~m_dots[i];

    if ((m_t % F) == 0) begin
      m_num    = number;
      m_dots   = dots;
      m_en     = digit_en;
      m_bright = brightness;
    end
    m_t++;
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      step();
      @(negedge clk);
      #1;
    end
  endtask

  task automatic randomize_inputs();
    number   = 16'($urandom);
    dots     = N'($urandom);
    digit_en = N'($urandom);
    case ($urandom_range(0, 3))
      0:       brightness = '0;
      1:       brightness = '1;
      default: brightness = BW'($urandom);
    endcase
    if ($urandom_range(0, 3) == 0) number = 16'($urandom_range(0, 255));
  endtask

  task automatic run_random(input int cycles);
    repeat (cycles) begin
      if ($urandom_range(0, 19) == 0) randomize_inputs();
      step();
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst        = 1'b1;
    number     = '0;
    dots       = '0;
    digit_en   = '0;
    brightness = '0;
    m_t        = 0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("por");

    // Full brightness scan of 12AF across all digits.
    number     = 16'h12AF;
    digit_en   = 4'hF;
    dots       = 4'b0101;
    brightness = 4'hF;
    release_rst();
    run(2 * F);

    // Mid-frame number change must wait for the next frame start.
    number = 16'h1111;
    run(F + 24);
    number = 16'h2222;
    run(F + 8);

    // Partial duty, then fully dark.
    brightness = 4'h4;
    run(F + 3);
    brightness = 4'h0;
    run(2 * F);

    // Leading zeros.
    number     = 16'h0050;
    brightness = 4'hF;
    digit_en   = 4'hF;
    run(2 * F + 5);

    run_random(20 * F);

    // Asynchronous reset asserted mid-slot.
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    check_reset_values("rst_held");
    @(negedge clk);
    #1;
    randomize_inputs();
    release_rst();
    run_random(10 * F);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
